// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks; holds the arbiter state encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant pick between instruction and data requesters.
// ARB_ROUND_ROBIN_EN: alternate on simultaneous requests, else data side has fixed priority.
module arb_grant (
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_d,
`endif
    output logic grant_any,
    output logic grant_d
);

    always_comb begin
        grant_any = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_d = ~last_d;
        end else begin
            grant_d = d_req;
        end
`else
        grant_d = d_req;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to single-port memory arbiter, one transaction in flight.
// ARB_ROUND_ROBIN_EN selects alternating arbitration; default is fixed data priority.
//
// state  | meaning
// IDLE   | sampling requests, nothing outstanding downstream
// I_BUSY | instruction request latched and presented on pmem
// D_BUSY | data request latched and presented on pmem
// RESP   | one-cycle completion pulse to the granted side
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   imem_address,
    input  logic                imem_read,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_resp,

    input  logic [ADDR_W-1:0]   dmem_address,
    input  logic                dmem_read,
    input  logic                dmem_write,
    input  logic [DATA_W/8-1:0] dmem_wmask,
    input  logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_resp,

    output logic [ADDR_W-1:0]   pmem_address,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [DATA_W/8-1:0] pmem_wmask,
    output logic [DATA_W-1:0]   pmem_wdata,
    input  logic [DATA_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t state, state_nxt;

    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_wmask;
    logic              lat_write;
    logic              lat_d;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic i_req, d_req, grant_any, grant_d, busy, take;

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;
    assign busy  = (state == I_BUSY) || (state == D_BUSY);
    assign take  = (state == IDLE) && grant_any;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    arb_grant u_grant (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_d    (last_d),
        .grant_any (grant_any),
        .grant_d   (grant_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (take) begin
            last_d <= grant_d;
        end
    end
`else
    arb_grant u_grant (
        .i_req     (i_req),
        .d_req     (d_req),
        .grant_any (grant_any),
        .grant_d   (grant_d)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = grant_d ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream port is fed only from the request captured at grant time,
    // so the requester may change its live inputs while the access is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_write <= 1'b0;
            lat_d     <= 1'b0;
        end else if (take) begin
            lat_d <= grant_d;
            if (grant_d) begin
                lat_addr  <= dmem_address;
                lat_wdata <= dmem_wdata;
                lat_wmask <= dmem_wmask;
                lat_write <= dmem_write;
            end else begin
                lat_addr  <= imem_address;
                lat_wdata <= '0;
                lat_wmask <= '0;
                lat_write <= 1'b0;
            end
        end
    end

    // Write completions leave the read-data registers untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (busy && pmem_resp && !lat_write) begin
            if (lat_d) begin
                d_rdata_q <= pmem_rdata;
            end else begin
                i_rdata_q <= pmem_rdata;
            end
        end
    end

    assign pmem_address = lat_addr;
    assign pmem_wdata   = lat_wdata;
    assign pmem_wmask   = lat_wmask;
    assign pmem_read    = busy & ~lat_write;
    assign pmem_write   = busy & lat_write;

    assign imem_resp  = (state == RESP) && !lat_d;
    assign dmem_resp  = (state == RESP) && lat_d;
    assign imem_rdata = i_rdata_q;
    assign dmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; arbitration expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] imem_address;
    logic              imem_read;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_resp;
    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [3:0]        dmem_wmask;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [3:0]        pmem_wmask;
    logic [DATA_W-1:0] pmem_wdata;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_ird = 32'h0;
    logic [31:0] exp_drd = 32'h0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wmask   (pmem_wmask),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from a request already raised in IDLE: wait for the
    // downstream request, hold it 'hold' cycles while live inputs are disturbed,
    // answer with rd, then check the completion pulse and the read-data registers.
    task automatic run_txn(input string tag, input logic exp_d, input logic exp_wr,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wmask, input logic [31:0] rd,
                           input int hold, input logic drop, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (pmem_read || pmem_write) seen = 1'b1;
        end
        check({tag, "_req_seen"}, 64'(seen), 64'(1));
        if (!seen) return;

        if (exp_d) begin
            dmem_address = dmem_address + 32'h100;
            dmem_wdata   = ~dmem_wdata;
            dmem_wmask   = ~dmem_wmask;
        end else begin
            imem_address = imem_address + 32'h100;
        end

        for (int c = 1; c <= hold; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check({tag, "_addr"},  64'(pmem_address), 64'(exp_addr));
            check({tag, "_pwr"},   64'(pmem_write), 64'(exp_wr));
            check({tag, "_prd"},   64'(pmem_read), 64'(!exp_wr));
            check({tag, "_nores"}, 64'({imem_resp, dmem_resp}), 64'(0));
            if (exp_wr) begin
                check({tag, "_wdata"}, 64'(pmem_wdata), 64'(exp_wdata));
                check({tag, "_wmask"}, 64'(pmem_wmask), 64'(exp_wmask));
            end
        end

        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = 32'hBAD0_BAD0;

        if (!exp_wr) begin
            if (exp_d) exp_drd = rd;
            else       exp_ird = rd;
        end
        check({tag, "_iresp"}, 64'(imem_resp), 64'(!exp_d));
        check({tag, "_dresp"}, 64'(dmem_resp), 64'(exp_d));
        check({tag, "_pidle"}, 64'({pmem_read, pmem_write}), 64'(0));
        check({tag, "_irdata"}, 64'(imem_rdata), 64'(exp_ird));
        check({tag, "_drdata"}, 64'(dmem_rdata), 64'(exp_drd));

        if (drop) begin
            if (exp_d) begin
                dmem_read  = 1'b0;
                dmem_write = 1'b0;
            end else begin
                imem_read = 1'b0;
            end
        end

        @(posedge clk); #1;
        check({tag, "_pulse1"}, 64'({imem_resp, dmem_resp}), 64'(0));
        check({tag, "_idle"},   64'({pmem_read, pmem_write}), 64'(0));
    endtask

    initial begin
        int  lat;
        logic seen;

        rst          = 1'b0;
        imem_address = '0;
        imem_read    = 1'b0;
        dmem_address = '0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_wmask   = '0;
        dmem_wdata   = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;

        #22;
        check("rst_pmem_rw",   64'({pmem_read, pmem_write}), 64'(0));
        check("rst_pmem_addr", 64'(pmem_address), 64'(0));
        check("rst_pmem_wd",   64'({pmem_wdata, pmem_wmask}), 64'(0));
        check("rst_resp",      64'({imem_resp, dmem_resp}), 64'(0));
        check("rst_rdata",     64'({imem_rdata, dmem_rdata}), 64'(0));

        @(posedge clk); #1;
        rst = 1'b1;

        // Instruction fetch, response three cycles after the request.
        imem_address = 32'h6000_0000;
        imem_read    = 1'b1;
        run_txn("ifetch", 1'b0, 1'b0, 32'h6000_0000, 32'h0, 4'h0, 32'h0000_0013, 3, 1'b1, lat);
        check("ifetch_lat", 64'(lat), 64'(1));

        // Data read to give dmem_rdata a known nonzero value.
        dmem_address = 32'h0000_2000;
        dmem_read    = 1'b1;
        run_txn("dread", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'hA5A5_0001, 2, 1'b1, lat);

        // Full-word data write; dmem_rdata must keep the previous read value.
        dmem_address = 32'h0000_1004;
        dmem_wdata   = 32'hDEAD_BEEF;
        dmem_wmask   = 4'hF;
        dmem_write   = 1'b1;
        run_txn("dwrite", 1'b1, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 32'h7777_7777, 4, 1'b1, lat);
        check("dwrite_lat", 64'(lat), 64'(1));

        // Read and write together behave as a partial write.
        dmem_address = 32'h0000_3000;
        dmem_wdata   = 32'h1122_3344;
        dmem_wmask   = 4'h3;
        dmem_read    = 1'b1;
        dmem_write   = 1'b1;
        run_txn("drw", 1'b1, 1'b1, 32'h0000_3000, 32'h1122_3344, 4'h3, 32'h6666_6666, 2, 1'b1, lat);

        // Live address moves 0x100 -> 0x200 while in flight; pmem must stay at 0x100.
        dmem_address = 32'h0000_0100;
        dmem_read    = 1'b1;
        run_txn("dstable", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0BAD_F00D, 3, 1'b1, lat);

        // Simultaneous requests, twice in a row.
        imem_address = 32'h0000_4000;
        imem_read    = 1'b1;
        dmem_address = 32'h0000_5000;
        dmem_read    = 1'b1;
        run_txn("arb1", 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h0000_00D1, 2, 1'b0, lat);
        check("arb1_lat", 64'(lat), 64'(1));
        dmem_address = 32'h0000_5800;
`ifdef ARB_ROUND_ROBIN_EN
        run_txn("arb2", 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h0000_0011, 2, 1'b1, lat);
        check("arb2_lat", 64'(lat), 64'(1));
        run_txn("arb3", 1'b1, 1'b0, 32'h0000_5800, 32'h0, 4'h0, 32'h0000_00D3, 2, 1'b1, lat);
`else
        run_txn("arb2", 1'b1, 1'b0, 32'h0000_5800, 32'h0, 4'h0, 32'h0000_00D2, 2, 1'b1, lat);
        check("arb2_lat", 64'(lat), 64'(1));
        run_txn("arb3", 1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h0000_0011, 2, 1'b1, lat);
`endif

        // Stray downstream response while idle.
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        check("stray_resp",  64'({imem_resp, dmem_resp}), 64'(0));
        check("stray_rdata", 64'({imem_rdata, dmem_rdata}), {exp_ird, exp_drd});
        check("stray_pmem",  64'({pmem_read, pmem_write}), 64'(0));
        @(posedge clk); #1;
        check("stray_resp2", 64'({imem_resp, dmem_resp}), 64'(0));

        // Reset in the middle of a data read, then a late response.
        dmem_address = 32'h0000_7000;
        dmem_read    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (pmem_read) seen = 1'b1;
        end
        check("mrst_req_seen", 64'(seen), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mrst_pread", 64'({pmem_read, pmem_write}), 64'(0));
        check("mrst_paddr", 64'(pmem_address), 64'(0));
        check("mrst_resp",  64'({imem_resp, dmem_resp}), 64'(0));
        dmem_read = 1'b0;
        exp_ird   = 32'h0;
        exp_drd   = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        check("late_resp",  64'({imem_resp, dmem_resp}), 64'(0));
        check("late_rdata", 64'({imem_rdata, dmem_rdata}), 64'(0));
        check("late_pmem",  64'({pmem_read, pmem_write}), 64'(0));
        @(posedge clk); #1;
        check("late_resp2", 64'({imem_resp, dmem_resp}), 64'(0));

        // Arbiter is back in IDLE and serves a fresh fetch with minimum latency.
        imem_address = 32'h6000_0010;
        imem_read    = 1'b1;
        run_txn("post", 1'b0, 1'b0, 32'h6000_0010, 32'h0, 4'h0, 32'hCAFE_0001, 1, 1'b1, lat);
        check("post_lat", 64'(lat), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
